// File: rtl/timer_cfg_seq_if.sv
// Config handshake between the register block (master) and the timer config sequencer (slave).
// Latency: none, wires only; backpressure: the master holds cfg_req and data until cfg_ready.
interface timer_cfg_seq_if #(
    parameter int DIV_W = 4
);
    logic             cfg_req;
    logic             cfg_timer_en;
    logic             cfg_div_en;
    logic [DIV_W-1:0] cfg_div_val;
    logic             cfg_ready;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
        output cfg_req, cfg_timer_en, cfg_div_en, cfg_div_val,
        input  cfg_ready, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_req, cfg_timer_en, cfg_div_en, cfg_div_val,
        output cfg_ready, cfg_done, cfg_err
    );
endinterface

// File: rtl/timer_cfg_seq.sv
// Sequences timer/divider config updates into the prescaler and owns the debug halt request.
// Latency: 1 cycle fast/reject, SETTLE_CYC+2 on divider change; backpressure: cfg_ready low outside IDLE or while halted.
module timer_cfg_seq #(
    parameter int DIV_W      = 4,
    parameter int MAX_DIV    = 8,
    parameter int SETTLE_CYC = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             dbg_mode,
    input  logic             halt_req,
    input  logic             halt_ack,
    timer_cfg_seq_if.slave   cfg,
    output logic             timer_en,
    output logic             div_en,
    output logic [DIV_W-1:0] div_val,
    output logic             halt_reg,
    output logic             halted
);
    typedef enum logic [1:0] {IDLE, DRAIN, APPLY, RESUME} state_t;

    localparam logic [DIV_W-1:0] MAX_DIV_C   = DIV_W'(MAX_DIV);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             timer_en_q, timer_en_d;
    logic             div_en_q, div_en_d;
    logic [DIV_W-1:0] div_val_q, div_val_d;
    logic             halt_reg_q, halt_reg_d;
    logic             cfg_done_q, cfg_done_d;
    logic             cfg_err_q, cfg_err_d;
    logic             halted_q;
    logic             sh_timer_en_q, sh_timer_en_d;
    logic             sh_div_en_q, sh_div_en_d;
    logic [DIV_W-1:0] sh_div_val_q, sh_div_val_d;

    logic cfg_ready;
    logic xfer;
    logic halt_cond;
    logic same_div;

    assign cfg_ready = (state_q == IDLE) & ~halt_reg_q;
    assign xfer      = cfg.cfg_req & cfg_ready;
    assign halt_cond = dbg_mode & halt_req;
    assign same_div  = (cfg.cfg_div_en == div_en_q) & (cfg.cfg_div_val == div_val_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timer_en_d    = timer_en_q;
        div_en_d      = div_en_q;
        div_val_d     = div_val_q;
        halt_reg_d    = halt_reg_q;
        cfg_done_d    = 1'b0;
        cfg_err_d     = 1'b0;
        sh_timer_en_d = sh_timer_en_q;
        sh_div_en_d   = sh_div_en_q;
        sh_div_val_d  = sh_div_val_q;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (cfg.cfg_div_val > MAX_DIV_C) begin
                        cfg_err_d = 1'b1;
                    end else if (!timer_en_q || same_div) begin
                        timer_en_d = cfg.cfg_timer_en;
                        div_en_d   = cfg.cfg_div_en;
                        div_val_d  = cfg.cfg_div_val;
                        cfg_done_d = 1'b1;
                    end else begin
                        sh_timer_en_d = cfg.cfg_timer_en;
                        sh_div_en_d   = cfg.cfg_div_en;
                        sh_div_val_d  = cfg.cfg_div_val;
                        timer_en_d    = 1'b0;
                        cnt_d         = 4'd0;
                        state_d       = DRAIN;
                    end
                end else begin
                    // A same-cycle cfg transfer takes priority; halt is picked up later.
                    halt_reg_d = halt_cond;
                end
            end
            DRAIN: begin
                if (cnt_q == SETTLE_LAST) begin
                    div_en_d  = sh_div_en_q;
                    div_val_d = sh_div_val_q;
                    state_d   = APPLY;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            APPLY: begin
                timer_en_d = sh_timer_en_q;
                cfg_done_d = 1'b1;
                state_d    = RESUME;
            end
            RESUME: begin
                // Deferred halt lands as the sequence hands back to IDLE.
                halt_reg_d = halt_cond;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            timer_en_q    <= 1'b0;
            div_en_q      <= 1'b0;
            div_val_q     <= '0;
            halt_reg_q    <= 1'b0;
            cfg_done_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            halted_q      <= 1'b0;
            sh_timer_en_q <= 1'b0;
            sh_div_en_q   <= 1'b0;
            sh_div_val_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timer_en_q    <= timer_en_d;
            div_en_q      <= div_en_d;
            div_val_q     <= div_val_d;
            halt_reg_q    <= halt_reg_d;
            cfg_done_q    <= cfg_done_d;
            cfg_err_q     <= cfg_err_d;
            halted_q      <= halt_ack;
            sh_timer_en_q <= sh_timer_en_d;
            sh_div_en_q   <= sh_div_en_d;
            sh_div_val_q  <= sh_div_val_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready;
    assign cfg.cfg_done  = cfg_done_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign timer_en      = timer_en_q;
    assign div_en        = div_en_q;
    assign div_val       = div_val_q;
    assign halt_reg      = halt_reg_q;
    assign halted        = halted_q;
endmodule

// File: tb/tb_timer_cfg_seq.sv
// Scoreboarded bench for timer_cfg_seq: directed scenarios, then randomized config traffic with random halts.
module tb_timer_cfg_seq;
    localparam int DIV_W      = 4;
    localparam int MAX_DIV    = 8;
    localparam int SETTLE_CYC = 1;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             dbg_mode = 1'b0;
    logic             halt_req = 1'b0;
    logic             halt_ack = 1'b0;
    logic             timer_en, div_en, halt_reg, halted;
    logic [DIV_W-1:0] div_val;

    timer_cfg_seq_if #(.DIV_W(DIV_W)) cfg_if ();

    timer_cfg_seq #(.DIV_W(DIV_W), .MAX_DIV(MAX_DIV), .SETTLE_CYC(SETTLE_CYC)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .dbg_mode (dbg_mode),
        .halt_req (halt_req),
        .halt_ack (halt_ack),
        .cfg      (cfg_if),
        .timer_en (timer_en),
        .div_en   (div_en),
        .div_val  (div_val),
        .halt_reg (halt_reg),
        .halted   (halted)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        bit               err;
        bit               te;
        bit               de;
        logic [DIV_W-1:0] dv;
        int               t;
        int               lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model: the committed prescaler configuration.
    bit               m_te = 1'b0;
    bit               m_de = 1'b0;
    logic [DIV_W-1:0] m_dv = '0;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  rnd_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Call at a negedge; returns just after the accepting posedge with t_acc = cycle of acceptance.
    task automatic send(input bit te, input bit de, input logic [DIV_W-1:0] dv, output int t_acc);
        int   waitc;
        exp_t e;
        waitc = 0;
        cfg_if.cfg_timer_en = te;
        cfg_if.cfg_div_en   = de;
        cfg_if.cfg_div_val  = dv;
        cfg_if.cfg_req      = 1'b1;
        while (!cfg_if.cfg_ready && waitc < 200) begin
            @(negedge sys_clk);
            waitc++;
        end
        chk("accept", int'(cfg_if.cfg_ready), 1);
        if (!cfg_if.cfg_ready) begin
            cfg_if.cfg_req = 1'b0;
            t_acc = -1;
            return;
        end
        t_acc = cyc;
        e.t   = t_acc;
        if (int'(dv) > MAX_DIV) begin
            e.err = 1'b1; e.te = m_te; e.de = m_de; e.dv = m_dv; e.lat = 1;
        end else begin
            e.err = 1'b0;
            e.lat = (!m_te || (de == m_de && dv == m_dv)) ? 1 : SETTLE_CYC + 2;
            m_te = te; m_de = de; m_dv = dv;
            e.te = te; e.de = de; e.dv = dv;
        end
        sb.push_back(e);
        @(posedge sys_clk);
        #1;
        cfg_if.cfg_req = 1'b0;
    endtask

    // Response monitor: every done/err pulse must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (!sys_rst && (cfg_if.cfg_done || cfg_if.cfg_err)) begin
            chk("done_err_exclusive", int'(cfg_if.cfg_done & cfg_if.cfg_err), 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: done=%0d err=%0d with no outstanding request (cycle %0d)",
                         cfg_if.cfg_done, cfg_if.cfg_err, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_is_err", int'(cfg_if.cfg_err), int'(mon_e.err));
                chk("resp_cycle", cyc, mon_e.t + mon_e.lat);
                chk("resp_timer_en", int'(timer_en), int'(mon_e.te));
                chk("resp_div_en", int'(div_en), int'(mon_e.de));
                chk("resp_div_val", int'(div_val), int'(mon_e.dv));
            end
        end
    end

    // halt_ack driver and halted-delay checker.
    initial begin
        bit prev_ack;
        bit was_rst;
        prev_ack = 1'b0;
        was_rst  = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                was_rst = 1'b1;
            end else begin
                if (!was_rst) chk("halted_delay", int'(halted), int'(prev_ack));
                was_rst = 1'b0;
            end
            halt_ack = 1'($urandom);
            prev_ack = halt_ack;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, hd;
        cfg_if.cfg_req      = 1'b0;
        cfg_if.cfg_timer_en = 1'b0;
        cfg_if.cfg_div_en   = 1'b0;
        cfg_if.cfg_div_val  = '0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_timer_en", int'(timer_en), 0);
        chk("rst_div_en", int'(div_en), 0);
        chk("rst_div_val", int'(div_val), 0);
        chk("rst_halt_reg", int'(halt_reg), 0);
        chk("rst_cfg_done", int'(cfg_if.cfg_done), 0);
        chk("rst_cfg_err", int'(cfg_if.cfg_err), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_ready", int'(cfg_if.cfg_ready), 1);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Fast path from a stopped timer
        send(1'b1, 1'b1, 4'd3, t);
        @(negedge sys_clk);
        chk("fast_timer_en", int'(timer_en), 1);
        chk("fast_div_en", int'(div_en), 1);
        chk("fast_div_val", int'(div_val), 3);
        chk("fast_ready", int'(cfg_if.cfg_ready), 1);

        // Slow path: running timer, divider change
        send(1'b1, 1'b1, 4'd5, t);
        for (int k = 1; k <= 4; k++) begin
            @(negedge sys_clk);
            chk("slow_ready", int'(cfg_if.cfg_ready), (k == 4) ? 1 : 0);
            if (k <= 3) chk("slow_timer_en", int'(timer_en), (k == 3) ? 1 : 0);
            if (k == 1) chk("slow_div_val_old", int'(div_val), 3);
            if (k == 2) chk("slow_div_val_new", int'(div_val), 5);
        end

        // Illegal divider code
        send(1'b1, 1'b1, 4'd9, t);
        @(negedge sys_clk);
        chk("illegal_timer_en", int'(timer_en), 1);
        chk("illegal_div_en", int'(div_en), 1);
        chk("illegal_div_val", int'(div_val), 5);
        chk("illegal_ready", int'(cfg_if.cfg_ready), 1);

        // Reset in the middle of DRAIN
        send(1'b1, 1'b1, 4'd7, t);
        @(negedge sys_clk);
        chk("drain_timer_en", int'(timer_en), 0);
        sys_rst = 1'b1;
        #1;
        chk("midrst_timer_en", int'(timer_en), 0);
        chk("midrst_div_en", int'(div_en), 0);
        chk("midrst_div_val", int'(div_val), 0);
        chk("midrst_ready", int'(cfg_if.cfg_ready), 1);
        sb.delete();
        m_te = 1'b0; m_de = 1'b0; m_dv = '0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            chk("postrst_no_done", int'(cfg_if.cfg_done), 0);
            chk("postrst_ready", int'(cfg_if.cfg_ready), 1);
        end

        // Debug halt with a held config request
        dbg_mode = 1'b1;
        halt_req = 1'b1;
        @(negedge sys_clk);
        chk("halt_reg_set", int'(halt_reg), 1);
        chk("halt_ready", int'(cfg_if.cfg_ready), 0);
        hd = 0;
        fork
            send(1'b1, 1'b1, 4'd2, t);
            begin
                repeat (4) @(negedge sys_clk);
                chk("halt_hold_timer_en", int'(timer_en), 0);
                halt_req = 1'b0;
                hd = cyc;
            end
        join
        chk("halt_accept_cycle", t, hd + 1);
        @(negedge sys_clk);
        chk("halt_cfg_div_val", int'(div_val), 2);

        // Collision: slow-path transfer and halt request together
        halt_req = 1'b1;
        send(1'b1, 1'b0, 4'd4, t);
        for (int k = 1; k <= 4; k++) begin
            @(negedge sys_clk);
            chk("collide_halt_reg", int'(halt_reg), (k == 4) ? 1 : 0);
        end
        halt_req = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("collide_halt_clear", int'(halt_reg), 0);

        // Randomized traffic with sporadic halts
        fork
            begin
                bit               te, de;
                logic [DIV_W-1:0] dv;
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge sys_clk);
                    te = ($urandom % 4) != 0;
                    if ($urandom % 4 == 0) begin
                        de = m_de;
                        dv = m_dv;
                    end else begin
                        de = 1'($urandom);
                        dv = DIV_W'($urandom_range(0, 10));
                    end
                    send(te, de, dv, t);
                    @(negedge sys_clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge sys_clk);
                    if ($urandom % 30 == 0) begin
                        halt_req = 1'b1;
                        repeat ($urandom_range(1, 4)) @(negedge sys_clk);
                        halt_req = 1'b0;
                    end
                end
            end
        join

        halt_req = 1'b0;
        repeat (10) @(negedge sys_clk);
        chk("sb_drained", sb.size(), 0);
        chk("final_halt_reg", int'(halt_reg), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
